// File: rtl/sram_pkg.sv
// sram_pkg: shared types, sizing helpers and byte-merge function for sram_2p_pipe
package sram_pkg;
  localparam int MAX_W = 256;
  typedef logic [MAX_W-1:0] word_t;
  typedef logic [MAX_W/8-1:0] be_t;
  typedef logic [1:0] fptr_t;
  typedef logic [2:0] cnt_t;
  function automatic int aw_of(int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
  function automatic int fd_of(int out_reg);
    return out_reg + 2;
  endfunction
  function automatic word_t be_merge(word_t old_w, word_t new_w, be_t be);
    word_t r;
    r = old_w;
    for (int i = 0; i < MAX_W / 8; i++)
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/sram_2p_pipe_if.sv
// sram_2p_pipe_if: write port and credit read request/response bus of sram_2p_pipe
// master drives WR_* / RD_REQ / RD_ADDR / RD_RDY; slave drives RD_GNT / RD_VAL / RD_DATA
interface sram_2p_pipe_if #(parameter int WIDTH = 32, parameter int AW = 10);
  logic             WR_EN;
  logic [AW-1:0]    WR_ADDR;
  logic [WIDTH/8-1:0] WR_BE;
  logic [WIDTH-1:0] WR_DATA;
  logic             RD_REQ;
  logic [AW-1:0]    RD_ADDR;
  logic             RD_GNT;
  logic             RD_VAL;
  logic [WIDTH-1:0] RD_DATA;
  logic             RD_RDY;
  modport master(output WR_EN, WR_ADDR, WR_BE, WR_DATA, RD_REQ, RD_ADDR, RD_RDY,
                 input RD_GNT, RD_VAL, RD_DATA);
  modport slave(input WR_EN, WR_ADDR, WR_BE, WR_DATA, RD_REQ, RD_ADDR, RD_RDY,
                output RD_GNT, RD_VAL, RD_DATA);
endinterface

// File: rtl/sram_resp_fifo.sv
// sram_resp_fifo: first-word-fall-through response FIFO (DEPTH <= 4)
// ports: CLK, RST, push/din, pop, dout (head entry), full, empty, count
module sram_resp_fifo import sram_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output cnt_t             count
);
  logic [WIDTH-1:0] mem [DEPTH];
  fptr_t wptr, rptr;
  logic do_pop;
  function automatic fptr_t inc(fptr_t p);
    return (p == fptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign empty  = count == '0;
  assign full   = count == cnt_t'(DEPTH);
  assign do_pop = pop && !empty;
  assign dout   = mem[rptr];
  // storage is cleared so the head reads as zero straight out of reset
  always_ff @(posedge CLK)
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= din;
        wptr      <= inc(wptr);
      end
      if (do_pop) rptr <= inc(rptr);
      count <= count + cnt_t'(push) - cnt_t'(do_pop);
    end
endmodule

// File: rtl/sram_2p_pipe.sv
// sram_2p_pipe: two-port SRAM, byte-enabled writes, optional output register, credit-gated FWFT responses
// ports: CLK, RST (sync, active-high), bus (sram_2p_pipe_if.slave)
// option: define SRAM_RDW_BYPASS_EN to forward same-cycle write data to a same-address read
module sram_2p_pipe import sram_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 1024,
  parameter int OUT_REG = 1
) (
  input logic          CLK,
  input logic          RST,
  sram_2p_pipe_if.slave bus
);
  localparam int FD = fd_of(OUT_REG);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_word, push_d;
  logic accept, push, inflight, full, empty;
  cnt_t count;
  assign accept = bus.RD_REQ && bus.RD_GNT;
  // credits cover the pipeline stage and every FIFO slot, so a response always has room
  assign bus.RD_GNT = (cnt_t'(inflight) + count) < cnt_t'(FD);
  assign bus.RD_VAL = !empty;
`ifdef SRAM_RDW_BYPASS_EN
  assign rd_word = (bus.WR_EN && bus.WR_ADDR == bus.RD_ADDR)
    ? WIDTH'(be_merge(word_t'(mem[bus.RD_ADDR]), word_t'(bus.WR_DATA), be_t'(bus.WR_BE)))
    : mem[bus.RD_ADDR];
`else
  assign rd_word = mem[bus.RD_ADDR];
`endif
  always_ff @(posedge CLK)
    if (bus.WR_EN)
      mem[bus.WR_ADDR] <= WIDTH'(be_merge(word_t'(mem[bus.WR_ADDR]), word_t'(bus.WR_DATA), be_t'(bus.WR_BE)));
  generate
    if (OUT_REG != 0) begin : g_reg
      logic pipe_v;
      logic [WIDTH-1:0] pipe_d;
      // free-running stage; backpressure is absorbed by the FIFO
      always_ff @(posedge CLK)
        if (RST) begin
          pipe_v <= 1'b0;
          pipe_d <= '0;
        end else begin
          pipe_v <= accept;
          pipe_d <= rd_word;
        end
      assign inflight = pipe_v;
      assign push     = pipe_v;
      assign push_d   = pipe_d;
    end else begin : g_comb
      assign inflight = 1'b0;
      assign push     = accept;
      assign push_d   = rd_word;
    end
  endgenerate
  sram_resp_fifo #(.WIDTH(WIDTH), .DEPTH(FD)) u_fifo (
    .CLK(CLK), .RST(RST), .push(push), .din(push_d), .pop(bus.RD_RDY),
    .dout(bus.RD_DATA), .full(full), .empty(empty), .count(count)
  );
  always @(posedge CLK)
    if (!RST) begin
      assert (!(push && full && !bus.RD_RDY)) else $error("resp fifo overflow");
      assert (!bus.WR_EN || !$isunknown({bus.WR_ADDR, bus.WR_BE})) else $error("unknown write addr/be");
      assert (!accept || !$isunknown(bus.RD_ADDR)) else $error("unknown read addr");
    end
endmodule

// File: tb/tb_sram_2p_pipe.sv
// tb_sram_2p_pipe: directed self-checking bench for sram_2p_pipe (OUT_REG=1, FD=3)
module tb_sram_2p_pipe;
  logic CLK = 1'b0;
  logic RST;
  int total = 0;
  int bad = 0;
  always #5 CLK = ~CLK;
  sram_2p_pipe_if #(.WIDTH(32), .AW(10)) bus ();
  sram_2p_pipe #(.WIDTH(32), .DEPTH(1024), .OUT_REG(1)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.WR_EN = 1'b1;
    bus.WR_ADDR = a;
    bus.WR_DATA = d;
    bus.WR_BE = be;
    tick;
    bus.WR_EN = 1'b0;
  endtask
  task automatic rd1(input string tag, input logic [9:0] a, input logic [31:0] exp);
    bus.RD_REQ = 1'b1;
    bus.RD_ADDR = a;
    chk({tag, "_gnt"}, {31'b0, bus.RD_GNT}, 32'd1);
    tick;
    bus.RD_REQ = 1'b0;
    chk({tag, "_val_t1"}, {31'b0, bus.RD_VAL}, 32'd0);
    tick;
    chk({tag, "_val_t2"}, {31'b0, bus.RD_VAL}, 32'd1);
    chk({tag, "_data"}, bus.RD_DATA, exp);
    tick;
  endtask
  initial begin
    logic [31:0] q[$];
    logic [31:0] rdw_exp;
    int naddr, got, nexp;
    logic g, gnt_next;
    RST = 1'b1;
    bus.WR_EN = 1'b0; bus.WR_ADDR = '0; bus.WR_BE = '0; bus.WR_DATA = '0;
    bus.RD_REQ = 1'b0; bus.RD_ADDR = '0; bus.RD_RDY = 1'b1;
    tick;
    tick;
    RST = 1'b0;
    chk("rst_val", {31'b0, bus.RD_VAL}, 32'd0);
    chk("rst_data", bus.RD_DATA, 32'd0);
    chk("rst_gnt", {31'b0, bus.RD_GNT}, 32'd1);
    wr(10'd5, 32'hDEADBEEF, 4'hF);
    rd1("full_wr", 10'd5, 32'hDEADBEEF);
    wr(10'd5, 32'h11223344, 4'hF);
    wr(10'd5, 32'hAABBCCDD, 4'b0101);
    rd1("part_wr", 10'd5, 32'h11BB33DD);
    wr(10'd5, 32'hFFFFFFFF, 4'h0);
    rd1("be0_noop", 10'd5, 32'h11BB33DD);
    for (int i = 0; i < 10; i++) wr(10'(i), 32'(i), 4'hF);
    bus.RD_RDY = 1'b0;
    naddr = 0;
    for (int k = 0; k < 8; k++) begin
      bus.RD_REQ = 1'b1;
      bus.RD_ADDR = 10'(naddr);
      g = bus.RD_GNT;
      tick;
      if (g) naddr++;
    end
    chk("bp_accepted", 32'(naddr), 32'd3);
    chk("bp_gnt_low", {31'b0, bus.RD_GNT}, 32'd0);
    chk("bp_head_val", {31'b0, bus.RD_VAL}, 32'd1);
    chk("bp_head_data", bus.RD_DATA, 32'd0);
    bus.RD_RDY = 1'b1;
    got = 0;
    gnt_next = 1'b0;
    for (int k = 0; k < 40 && got < 10; k++) begin
      if (gnt_next) chk("bp_gnt_rerise", {31'b0, bus.RD_GNT}, 32'd1);
      gnt_next = 1'b0;
      if (bus.RD_VAL) begin
        chk("bp_order", bus.RD_DATA, 32'(got));
        if (got == 0) gnt_next = 1'b1;
        got++;
      end
      bus.RD_REQ = naddr < 10;
      bus.RD_ADDR = 10'(naddr);
      g = bus.RD_GNT && bus.RD_REQ;
      tick;
      if (g) naddr++;
    end
    bus.RD_REQ = 1'b0;
    chk("bp_count", 32'(got), 32'd10);
    tick;
    tick;
    tick;
    chk("bp_no_dup", {31'b0, bus.RD_VAL}, 32'd0);
    nexp = 0;
    for (int k = 0; k < 68; k++) begin
      if (k < 64) chk("st_gnt", {31'b0, bus.RD_GNT}, 32'd1);
      chk("st_val", {31'b0, bus.RD_VAL}, {31'b0, k >= 2 && k < 66});
      if (bus.RD_VAL) begin
        chk("st_data", bus.RD_DATA, (q.size() > 0) ? q.pop_front() : 32'hBAD0BAD0);
        nexp++;
      end
      bus.RD_REQ = k < 64;
      bus.RD_ADDR = 10'(k % 10);
      if (k < 64) q.push_back(32'(k % 10));
      tick;
    end
    bus.RD_REQ = 1'b0;
    chk("st_count", 32'(nexp), 32'd64);
    wr(10'd7, 32'h0, 4'hF);
    bus.WR_EN = 1'b1; bus.WR_ADDR = 10'd7; bus.WR_DATA = 32'hCAFEF00D; bus.WR_BE = 4'hF;
    bus.RD_REQ = 1'b1; bus.RD_ADDR = 10'd7;
    tick;
    bus.WR_EN = 1'b0;
    bus.RD_REQ = 1'b0;
    tick;
`ifdef SRAM_RDW_BYPASS_EN
    rdw_exp = 32'hCAFEF00D;
`else
    rdw_exp = 32'h00000000;
`endif
    chk("rdw_val", {31'b0, bus.RD_VAL}, 32'd1);
    chk("rdw_data", bus.RD_DATA, rdw_exp);
    tick;
    rd1("rdw_after", 10'd7, 32'hCAFEF00D);
    bus.RD_RDY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.RD_REQ = 1'b1;
      bus.RD_ADDR = 10'(k + 1);
      if (k == 2) begin
        chk("mid_fifo_val", {31'b0, bus.RD_VAL}, 32'd1);
        RST = 1'b1;
      end
      tick;
    end
    bus.RD_REQ = 1'b0;
    chk("mid_rst_val", {31'b0, bus.RD_VAL}, 32'd0);
    chk("mid_rst_data", bus.RD_DATA, 32'd0);
    RST = 1'b0;
    chk("mid_rst_gnt", {31'b0, bus.RD_GNT}, 32'd1);
    bus.RD_RDY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("mid_no_stale", {31'b0, bus.RD_VAL}, 32'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
